// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with valid/ready flow control.
// Define FPMUL_RNE_EN for round-to-nearest-even; otherwise rounds toward zero.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             out_flags
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX_S = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_e;

  typedef struct packed {
    logic             v;
    logic             sign;
    logic [XW-1:0]    exp;
    logic [MAN_W:0]   ma;
    logic [MAN_W:0]   mb;
    kind_e            kind;
    logic             inv;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             v;
    logic             sign;
    logic [XW-1:0]    exp;
    logic [PW-1:0]    prod;
    kind_e            kind;
    logic             inv;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic             v;
    logic [W-1:0]     res;
    logic [3:0]       flags;
    logic [TAG_W-1:0] tag;
  } s3_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;

  logic adv1, adv2, adv3;

  always_comb begin
    adv3 = !s3_q.v || out_ready;
    adv2 = !s2_q.v || adv3;
    adv1 = !s1_q.v || adv2;
  end

  assign in_ready = adv1;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic za, zb, ia, ib, na, nb;
  logic snan, inf_zero, is_nan, is_inf, is_zero;

  always_comb begin
    ea = in_a[W-2:MAN_W];
    eb = in_b[W-2:MAN_W];
    fa = in_a[MAN_W-1:0];
    fb = in_b[MAN_W-1:0];
    za = ea == '0;
    zb = eb == '0;
    ia = (ea == '1) && (fa == '0);
    ib = (eb == '1) && (fb == '0);
    na = (ea == '1) && (fa != '0);
    nb = (eb == '1) && (fb != '0);
    snan = (na && !fa[MAN_W-1]) || (nb && !fb[MAN_W-1]);
    inf_zero = (ia && zb) || (za && ib);
    is_nan = na || nb || inf_zero;
    is_inf = !is_nan && (ia || ib);
    is_zero = !is_nan && !is_inf && (za || zb);
    s1_d = s1_q;
    if (adv1) begin
      s1_d.v    = in_valid;
      s1_d.sign = in_a[W-1] ^ in_b[W-1];
      s1_d.exp  = XW'(ea) + XW'(eb) - BIAS;
      s1_d.ma   = {1'b1, fa};
      s1_d.mb   = {1'b1, fb};
      s1_d.inv  = snan || inf_zero;
      s1_d.tag  = in_tag;
      unique case (1'b1)
        is_nan:  s1_d.kind = K_NAN;
        is_inf:  s1_d.kind = K_INF;
        is_zero: s1_d.kind = K_ZERO;
        default: s1_d.kind = K_NUM;
      endcase
    end
  end

  always_comb begin
    s2_d = s2_q;
    if (adv2) begin
      s2_d.v    = s1_q.v;
      s2_d.sign = s1_q.sign;
      s2_d.exp  = s1_q.exp;
      s2_d.prod = PW'(s1_q.ma) * PW'(s1_q.mb);
      s2_d.kind = s1_q.kind;
      s2_d.inv  = s1_q.inv;
      s2_d.tag  = s1_q.tag;
    end
  end

  logic                 top, guard, sticky, inc, inexact, ovf, unf;
  logic [PW-2:0]        nrm;
  logic [MAN_W-1:0]     frac;
  logic [MAN_W:0]       fr;
  logic signed [XW-1:0] ef;
  logic [W-1:0]         res;
  logic [3:0]           flags;

  always_comb begin
    top = s2_q.prod[PW-1];
    nrm = top ? s2_q.prod[PW-2:0] : {s2_q.prod[PW-3:0], 1'b0};
    frac = nrm[PW-2 -: MAN_W];
    guard = nrm[MAN_W];
    sticky = |nrm[MAN_W-1:0];
    inexact = guard || sticky;
`ifdef FPMUL_RNE_EN
    inc = guard && (sticky || frac[0]);
`else
    inc = 1'b0;
`endif
    fr = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    // A rounding carry leaves fr[MAN_W-1:0] at zero already.
    ef = $signed(s2_q.exp + XW'(top) + XW'(fr[MAN_W]));
    ovf = ef >= EMAX_S;
    unf = ef[XW-1] || (ef == '0);
    res = {s2_q.sign, ef[EXP_W-1:0], fr[MAN_W-1:0]};
    flags = {1'b0, 2'b00, inexact};
    unique case (s2_q.kind)
      K_NAN: begin
        res = QNAN;
        flags = {s2_q.inv, 3'b000};
      end
      K_INF: begin
        res = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags = '0;
      end
      K_ZERO: begin
        res = {s2_q.sign, {(W-1){1'b0}}};
        flags = '0;
      end
      default: begin
        if (ovf) begin
`ifdef FPMUL_RNE_EN
          res = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
          res = {s2_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
          flags = 4'b0101;
        end else if (unf) begin
          res = {s2_q.sign, {(W-1){1'b0}}};
          flags = 4'b0011;
        end
      end
    endcase
    s3_d = s3_q;
    if (adv3) begin
      s3_d.v     = s2_q.v;
      s3_d.res   = res;
      s3_d.flags = flags;
      s3_d.tag   = s2_q.tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign out_valid  = s3_q.v;
  assign out_result = s3_q.res;
  assign out_tag    = s3_q.tag;
  assign out_flags  = s3_q.flags;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed testbench for fp_mul_pipe in its FP32 configuration.
// Expected values for rounding and overflow follow FPMUL_RNE_EN.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;

`ifdef FPMUL_RNE_EN
  localparam logic [31:0] RND1 = 32'h3FC00002;
  localparam logic [31:0] RND2 = 32'h3FC00008;
  localparam logic [31:0] OVF  = 32'h7F800000;
`else
  localparam logic [31:0] RND1 = 32'h3FC00001;
  localparam logic [31:0] RND2 = 32'h3FC00007;
  localparam logic [31:0] OVF  = 32'h7F7FFFFF;
`endif

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_tag(out_tag),
    .out_flags(out_flags)
  );

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, output logic [31:0] r,
                       output logic [3:0] f, output logic [3:0] t,
                       output int lat);
    in_a = a;
    in_b = b;
    in_tag = tag;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    r = out_result;
    f = out_flags;
    t = out_tag;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_result !== '0 ||
        out_tag !== '0 || out_flags !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b r=%h t=%h f=%b want all zero",
               out_valid, out_result, out_tag, out_flags);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got rdy=%b v=%b want rdy=1 v=0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    logic [3:0] f, t;
    int lat;
    do_op(32'h3FC00000, 32'h40000000, 4'h5, r, f, t, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 3", lat);
    end
    checks++;
    if (r !== 32'h40400000) begin
      errors++;
      $display("FAIL basic_result: got %h want 40400000", r);
    end
    checks++;
    if (t !== 4'h5 || f !== 4'b0000) begin
      errors++;
      $display("FAIL basic_tag_flags: got t=%h f=%b want t=5 f=0000", t, f);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] r;
    logic [3:0] f, t;
    int lat;
    do_op(32'h3F800001, 32'h3FC00000, 4'h1, r, f, t, lat);
    checks++;
    if (r !== RND1 || f !== 4'b0001) begin
      errors++;
      $display("FAIL round_lsb: got %h f=%b want %h f=0001", r, f, RND1);
    end
    do_op(32'h3F800005, 32'h3FC00000, 4'h2, r, f, t, lat);
    checks++;
    if (r !== RND2 || f !== 4'b0001) begin
      errors++;
      $display("FAIL round_tie: got %h f=%b want %h f=0001", r, f, RND2);
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [7] = '{32'h7F800000, 32'hFF800000, 32'h00400000,
                            32'h7F800001, 32'hFFC00000, 32'h80000000,
                            32'h7F800000};
    logic [31:0] vb [7] = '{32'h00000000, 32'h40000000, 32'h40000000,
                            32'h3F800000, 32'h3F800000, 32'h40400000,
                            32'h7F800000};
    logic [31:0] vr [7] = '{32'h7FC00000, 32'hFF800000, 32'h00000000,
                            32'h7FC00000, 32'h7FC00000, 32'h80000000,
                            32'h7F800000};
    logic [3:0]  vf [7] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000,
                            4'b0000, 4'b0000, 4'b0000};
    logic [31:0] r;
    logic [3:0] f, t;
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], 4'(i), r, f, t, lat);
      checks++;
      if (r !== vr[i] || f !== vf[i]) begin
        errors++;
        $display("FAIL special_%0d: got %h f=%b want %h f=%b",
                 i, r, f, vr[i], vf[i]);
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] r;
    logic [3:0] f, t;
    int lat;
    do_op(32'h7F000000, 32'h7F000000, 4'h3, r, f, t, lat);
    checks++;
    if (r !== OVF || f !== 4'b0101) begin
      errors++;
      $display("FAIL overflow: got %h f=%b want %h f=0101", r, f, OVF);
    end
    do_op(32'h00800000, 32'h00800000, 4'h4, r, f, t, lat);
    checks++;
    if (r !== 32'h00000000 || f !== 4'b0011) begin
      errors++;
      $display("FAIL underflow: got %h f=%b want 00000000 f=0011", r, f);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [3] = '{32'h3FC00000, 32'h3F800001, 32'h40000000};
    logic [31:0] vb [3] = '{32'h40000000, 32'h3FC00000, 32'h40400000};
    logic [31:0] vr [3] = '{32'h40400000, RND1, 32'h40C00000};
    drain();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = va[i];
      in_b = vb[i];
      in_tag = 4'(10 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 4'(10 + k) ||
          out_result !== vr[k]) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b t=%h r=%h want v=1 t=%h r=%h",
                 k, out_valid, out_tag, out_result, 4'(10 + k), vr[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] bv [4] = '{32'h3F800000, 32'h40000000,
                            32'h40400000, 32'h40800000};
    drain();
    out_ready = 1'b0;
    in_a = 32'h3F800000;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_b = bv[i];
      in_tag = 4'(i + 1);
      checks++;
      if (in_ready !== (i < 3)) begin
        errors++;
        $display("FAIL bp_in_ready_%0d: got %b want %b", i, in_ready, i < 3);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    for (int h = 0; h < 3; h++) begin
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 4'h1 ||
          out_result !== 32'h3F800000 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v=%b t=%h r=%h rdy=%b want 1 1 3f800000 0",
                 h, out_valid, out_tag, out_result, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 4'(k + 1) ||
          out_result !== bv[k]) begin
        errors++;
        $display("FAIL bp_order_%0d: got v=%b t=%h r=%h want v=1 t=%h r=%h",
                 k, out_valid, out_tag, out_result, 4'(k + 1), bv[k]);
      end
      @(posedge clk); #1;
      if (k == 0) in_valid = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] r;
    logic [3:0] f, t;
    int lat;
    bit seen;
    drain();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 32'h3F800000;
    in_b = 32'h40000000;
    in_tag = 4'h7;
    @(posedge clk); #1;
    in_b = 32'h40400000;
    in_tag = 4'h8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_valid: got %b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_clear: got %b want 0", out_valid);
    end
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_emit: got %b want 0", seen);
    end
    do_op(32'h3FC00000, 32'h40000000, 4'h9, r, f, t, lat);
    checks++;
    if (lat !== 3 || r !== 32'h40400000 || t !== 4'h9) begin
      errors++;
      $display("FAIL mid_new_op: got lat=%0d r=%h t=%h want 3 40400000 9",
               lat, r, t);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_range();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
